// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter: merges ALU/LSU/MDU results onto the register-file write port |
// | and tracks pending long-latency destinations.              Revision 1.0  |
// +--------------------------------------------------------------------------+

module wb_arbiter_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  output logic              nonempty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count, count_next;
  logic              do_push, do_pop;

  // ready is registered, so an accepted push always has a free slot
  assign do_push   = push && ready;
  assign do_pop    = pop && nonempty;
  assign nonempty  = (count != '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      ready <= (count_next < CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end
endmodule

module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [ADDR_W-1:0]    lsu_addr,
  input  logic [DATA_W-1:0]    lsu_data,
  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic [ADDR_W-1:0]    mdu_addr,
  input  logic [DATA_W-1:0]    mdu_data,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data
);
  typedef enum logic [0:0] {LAST_LSU = 1'b0, LAST_MDU = 1'b1} last_t;

  last_t               last_q, last_d;
  logic                lsu_ne, mdu_ne, lsu_pop, mdu_pop;
  logic [ADDR_W-1:0]   lsu_head_addr, mdu_head_addr, fifo_addr;
  logic [DATA_W-1:0]   lsu_head_data, mdu_head_data, fifo_data;
  logic                alu_win, fifo_wr;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [2**ADDR_W-1:0] busy_d;

  wb_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (lsu_valid),
    .pop       (lsu_pop),
    .push_addr (lsu_addr),
    .push_data (lsu_data),
    .ready     (lsu_ready),
    .nonempty  (lsu_ne),
    .head_addr (lsu_head_addr),
    .head_data (lsu_head_data)
  );

  wb_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_mdu_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (mdu_valid),
    .pop       (mdu_pop),
    .push_addr (mdu_addr),
    .push_data (mdu_data),
    .ready     (mdu_ready),
    .nonempty  (mdu_ne),
    .head_addr (mdu_head_addr),
    .head_data (mdu_head_data)
  );

  assign alu_win = alu_valid && (alu_addr != '0);

  // Round-robin between buffered ports; ALU blocks both without moving the pointer
  always_comb begin
    lsu_pop = 1'b0;
    mdu_pop = 1'b0;
    last_d  = last_q;
    if (!alu_win) begin
      if (lsu_ne && (!mdu_ne || last_q == LAST_MDU)) begin
        lsu_pop = 1'b1;
        last_d  = LAST_LSU;
      end else if (mdu_ne) begin
        mdu_pop = 1'b1;
        last_d  = LAST_MDU;
      end
    end
  end

  assign fifo_addr = lsu_pop ? lsu_head_addr : mdu_head_addr;
  assign fifo_data = lsu_pop ? lsu_head_data : mdu_head_data;
  assign fifo_wr   = (lsu_pop || mdu_pop) && (fifo_addr != '0);

  always_comb begin
    wr_en_d   = alu_win || fifo_wr;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (alu_win) begin
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (fifo_wr) begin
      wr_addr_d = fifo_addr;
      wr_data_d = fifo_data;
    end
  end

  // Set applied after clear so a same-edge reissue keeps the register busy
  always_comb begin
    busy_d = busy;
    if (fifo_wr) busy_d[fifo_addr] = 1'b0;
    if (iss_en && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_q  <= LAST_MDU;
      busy    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      last_q  <= last_d;
      busy    <= busy_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// tb_wb_arbiter: directed plus randomized stimulus checked against a queue-based model.

module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              nrst;
  logic              alu_valid, lsu_valid, mdu_valid, iss_en;
  logic [ADDR_W-1:0] alu_addr, lsu_addr, mdu_addr, iss_addr;
  logic [DATA_W-1:0] alu_data, lsu_data, mdu_data;
  logic              lsu_ready, mdu_ready, wr_en;
  logic [31:0]       busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ports are plain queues, writes follow the priority rules directly
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              lq[$];
  ent_t              mq[$];
  logic [31:0]       m_busy;
  logic              m_lrdy, m_mrdy, m_en, m_chk_ad;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                m_last_mdu;

  task automatic tick();
    int          src;
    ent_t        e;
    logic [31:0] nb;
    src = 0;
    m_chk_ad = 1'b1;
    if (!nrst) begin
      lq.delete();
      mq.delete();
      m_busy = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
      m_lrdy = 1'b0; m_mrdy = 1'b0; m_last_mdu = 1'b1;
    end else begin
      if (alu_valid && alu_addr != 0) src = 1;
      else if (lq.size() > 0 && mq.size() > 0) src = m_last_mdu ? 2 : 3;
      else if (lq.size() > 0) src = 2;
      else if (mq.size() > 0) src = 3;
      nb = m_busy;
      m_en = 1'b0;
      if (src == 1) begin
        m_en = 1'b1; m_addr = alu_addr; m_data = alu_data;
      end else if (src != 0) begin
        e = (src == 2) ? lq.pop_front() : mq.pop_front();
        m_last_mdu = (src == 3);
        if (e.a != 0) begin
          m_en = 1'b1; m_addr = e.a; m_data = e.d; nb[e.a] = 1'b0;
        end else begin
          m_chk_ad = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
      m_busy = nb;
      if (lsu_valid && m_lrdy) lq.push_back({lsu_addr, lsu_data});
      if (mdu_valid && m_mrdy) mq.push_back({mdu_addr, mdu_data});
      m_lrdy = (lq.size() < DEPTH);
      m_mrdy = (mq.size() < DEPTH);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("wr_en", {63'd0, wr_en}, {63'd0, m_en});
    check_eq("busy", {32'd0, busy}, {32'd0, m_busy});
    check_eq("lsu_ready", {63'd0, lsu_ready}, {63'd0, m_lrdy});
    check_eq("mdu_ready", {63'd0, mdu_ready}, {63'd0, m_mrdy});
    if (m_chk_ad) begin
      check_eq("wr_addr", {59'd0, wr_addr}, {59'd0, m_addr});
      check_eq("wr_data", {32'd0, wr_data}, {32'd0, m_data});
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0; iss_en = 1'b0;
    alu_addr = '0; lsu_addr = '0; mdu_addr = '0; iss_addr = '0;
    alu_data = '0; lsu_data = '0; mdu_data = '0;
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    idle();
    nrst = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tick();

    // ALU single-cycle write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle_n(1);

    // Busy set by issue, cleared when the LSU result is written
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle(); lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h11;
    tick();
    idle_n(3);

    // Fill both FIFOs while the ALU blocks, then drain in round-robin order
    for (int k = 0; k < 2; k++) begin
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA0 + k;
      lsu_valid = 1'b1; lsu_addr = 5'd10 + 5'(k); lsu_data = 32'h100 + k;
      mdu_valid = 1'b1; mdu_addr = 5'd20 + 5'(k); mdu_data = 32'h200 + k;
      tick();
    end
    idle_n(6);

    // ALU held while LSU is full
    for (int k = 0; k < 5; k++) begin
      idle();
      alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hC0 + k;
      if (k < 2) begin lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'h300 + k; end
      tick();
    end
    idle_n(4);

    // x0 handling
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hBAD;
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h33;
    tick();
    idle(); alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hBAD2;
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h44;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle_n(3);

    // Reset with buffered entries and busy bits pending
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    for (int k = 0; k < 2; k++) begin
      idle();
      alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'hE0 + k;
      lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h900 + k;
      tick();
    end
    idle(); nrst = 1'b0;
    tick();
    nrst = 1'b1;
    idle_n(3);
    mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_data = 32'h4444;
    tick();
    idle_n(3);

    // Randomized traffic with phase-varying ALU load and rare resets
    for (int i = 0; i < 4000; i++) begin
      int alu_pct;
      alu_pct = ((i / 500) % 4) * 30;
      nrst      = ($urandom_range(0, 299) != 0);
      alu_valid = ($urandom_range(0, 99) < alu_pct);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 70);
      lsu_addr  = 5'($urandom_range(0, 9));
      lsu_data  = $urandom;
      mdu_valid = ($urandom_range(0, 99) < 50);
      mdu_addr  = 5'($urandom_range(0, 31));
      mdu_data  = $urandom;
      iss_en    = ($urandom_range(0, 99) < 40);
      iss_addr  = 5'($urandom_range(0, 15));
      tick();
    end
    nrst = 1'b1;
    idle_n(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
